matrix_mult_sched: RTL and testbench

Sequencing controller plus shared single-MAC datapath for an NxN by NxN matrix multiply, o = x·y, over M-bit unsigned words.
- Accepts a start/busy/done job handshake and latches both operand matrices.
- Steps i/j/k counters so the one multiplier-accumulator computes one product per cycle.
- Writes each finished element into a held output matrix.
- Sits between a host/test harness and the result consumer; the only sequential matrix-multiply engine in the design.

---
 rtl/matrix_mult_sched.sv | 118 +++++++++++
 tb/tb_matrix_mult_sched.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_mult_sched.sv
// Sequential NxN x NxN multiply on one shared MAC, one product per cycle; done pulses N^3+1 edges after start.
// No backpressure: start is taken only in IDLE, and o is held stable until the next job's LOAD clears it.
module matrix_mult_sched #(
  parameter int N = 3,
  parameter int M = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [M*N*N-1:0] x,
  input  logic [M*N*N-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [M*N*N-1:0] o
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam int W  = M * N * N;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  xl;
  logic [W-1:0]  yl;
  logic [CW-1:0] i;
  logic [CW-1:0] j;
  logic [CW-1:0] k;
  logic [M-1:0]  sum;
  logic [M-1:0]  a_el;
  logic [M-1:0]  b_el;
  logic [M-1:0]  acc;

  // Product and accumulate both wrap at M bits.
  always_comb begin
    a_el = xl[(int'(i) * N + int'(k)) * M +: M];
    b_el = yl[(int'(k) * N + int'(j)) * M +: M];
    acc  = sum + a_el * b_el;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      sum   <= '0;
      xl    <= '0;
      yl    <= '0;
      o     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          xl  <= x;
          yl  <= y;
          o   <= '0;
          sum <= '0;
          i   <= '0;
          j   <= '0;
          k   <= '0;
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            sum   <= '0;
            i     <= '0;
            j     <= '0;
            k     <= '0;
          end else if (k != LAST) begin
            sum <= acc;
            k   <= k + CW'(1);
          end else begin
            o[(int'(i) * N + int'(j)) * M +: M] <= acc;
            sum <= '0;
            k   <= '0;
            j   <= (j == LAST) ? '0 : j + CW'(1);
            if (j == LAST) begin
              // Wrapping i to 0 on the final element keeps every counter inside 0..N-1.
              if (i == LAST) begin
                i     <= '0;
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                i <= i + CW'(1);
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_mult_sched.sv
// Directed bench for matrix_mult_sched: expected result matrices go into a queue at job start and are checked when done pulses.
module tb_matrix_mult_sched;

  localparam int N = 3;
  localparam int M = 32;
  localparam int W = M * N * N;
  localparam int LAT = N * N * N + 1;

  typedef logic [W-1:0] mat_t;

  logic clk;
  logic rst;
  logic start;
  logic abort;
  mat_t x;
  mat_t y;
  logic busy;
  logic done;
  mat_t o;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  mat_t exp_q[$];

  matrix_mult_sched #(.N(N), .M(M)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .x     (x),
    .y     (y),
    .busy  (busy),
    .done  (done),
    .o     (o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk_i(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic chk_m(input string tag, input mat_t got, input mat_t expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  function automatic mat_t mk_seq(input logic [M-1:0] b, input logic [M-1:0] s);
    mat_t m;
    m = '0;
    for (int e = 0; e < N * N; e++) m[e*M +: M] = b + M'(e) * s;
    return m;
  endfunction

  function automatic mat_t mk_ident();
    mat_t m;
    m = '0;
    for (int r = 0; r < N; r++) m[(r*N + r)*M +: M] = 1;
    return m;
  endfunction

  function automatic mat_t mk_rand();
    mat_t m;
    for (int e = 0; e < N * N; e++) m[e*M +: M] = $urandom();
    return m;
  endfunction

  function automatic mat_t from_arr(input int unsigned a[9]);
    mat_t m;
    for (int e = 0; e < N * N; e++) m[e*M +: M] = a[e];
    return m;
  endfunction

  function automatic mat_t matmul(input mat_t a, input mat_t b);
    mat_t m;
    logic [M-1:0] s;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        s = '0;
        for (int q = 0; q < N; q++) s = s + a[(r*N + q)*M +: M] * b[(q*N + c)*M +: M];
        m[(r*N + c)*M +: M] = s;
      end
    return m;
  endfunction

  // Pulses start for one cycle; on return cyc=0 is the negedge just after the accepting edge.
  task automatic kick(input mat_t xa, input mat_t ya);
    @(negedge clk);
    x = xa;
    y = ya;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
  endtask

  task automatic finish_job(input bit clr_ops, input bit noisy, input string tag);
    int   busy_cnt;
    bit   overlap;
    mat_t e;
    busy_cnt = 0;
    overlap  = 1'b0;
    while (done !== 1'b1 && cyc < 200) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      cyc++;
      if (clr_ops && cyc == 1) begin
        x = '0;
        y = '0;
      end
      if (noisy) start = ($urandom_range(0, 2) == 0);
      if (busy === 1'b1 && done === 1'b1) overlap = 1'b1;
    end
    chk_i({tag, "_latency"}, 32'(cyc), 32'(LAT));
    chk_i({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(LAT));
    chk_i({tag, "_busy_at_done"}, 32'(busy), 32'(0));
    chk_i({tag, "_busy_done_overlap"}, 32'(overlap), 32'(0));
    chk_i({tag, "_queue_depth"}, 32'(exp_q.size()), 32'(1));
    if (done === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_m({tag, "_result"}, o, e);
    end
    if (noisy) start = 1'b1;
    @(negedge clk);
    cyc++;
    start = 1'b0;
    chk_i({tag, "_done_one_cycle"}, 32'(done), 32'(0));
    chk_i({tag, "_busy_after_done"}, 32'(busy), 32'(0));
  endtask

  initial begin
    int unsigned t3[9] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
    int unsigned t4[9] = '{30, 24, 0, 0, 0, 0, 0, 0, 0};
    mat_t m19;
    mat_t m91;
    mat_t xr;
    mat_t yr;
    int   dcnt;
    int   bcnt;

    m19   = mk_seq(32'd1, 32'd1);
    m91   = mk_seq(32'd9, 32'hFFFF_FFFF);
    rst   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    x     = '0;
    y     = '0;

    #12;
    chk_i("reset_busy", 32'(busy), 32'(0));
    chk_i("reset_done", 32'(done), 32'(0));
    chk_m("reset_o", o, '0);
    @(negedge clk);
    rst = 1'b1;

    // Identity times 1..9.
    exp_q.push_back(m19);
    kick(mk_ident(), m19);
    chk_i("t1_busy_after_start", 32'(busy), 32'(1));
    finish_job(1'b0, 1'b0, "t1");

    // Truncation and wrap.
    exp_q.push_back(mk_seq(32'hFFFF_FFFA, 32'd0));
    kick(mk_seq(32'hFFFF_FFFF, 32'd0), mk_seq(32'd2, 32'd0));
    finish_job(1'b0, 1'b0, "t2");

    // Operand ports zeroed after LOAD must not disturb the job.
    exp_q.push_back(from_arr(t3));
    kick(m19, m91);
    finish_job(1'b1, 1'b0, "t3");
    repeat (5) @(negedge clk);
    chk_m("t3_o_held", o, from_arr(t3));

    // Abort one cycle after o[0][1] is written at edge 7.
    kick(m19, m91);
    while (cyc < 7) begin
      @(negedge clk);
      cyc++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_i("t4_busy_after_abort", 32'(busy), 32'(0));
    chk_i("t4_done_after_abort", 32'(done), 32'(0));
    chk_m("t4_partial_o", o, from_arr(t4));
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    chk_i("t4_no_done", 32'(dcnt), 32'(0));
    chk_m("t4_partial_o_held", o, from_arr(t4));
    exp_q.push_back(from_arr(t3));
    kick(m19, m91);
    finish_job(1'b0, 1'b0, "t4_restart");

    // Random operands with start noise while busy and in DONE.
    xr = mk_rand();
    yr = mk_rand();
    exp_q.push_back(matmul(xr, yr));
    kick(xr, yr);
    finish_job(1'b0, 1'b1, "t5");
    dcnt = 0;
    bcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
      if (busy === 1'b1) bcnt++;
    end
    chk_i("t5_extra_done", 32'(dcnt), 32'(0));
    chk_i("t5_extra_busy", 32'(bcnt), 32'(0));
    chk_m("t5_o_held", o, matmul(xr, yr));
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    chk_i("t5_start_abort_idle", 32'(busy), 32'(0));
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk_i("t5_start_abort_idle2", 32'(busy), 32'(0));

    // Asynchronous reset in the middle of RUN.
    kick(mk_ident(), m19);
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    #2;
    rst = 1'b0;
    #1;
    chk_i("t6_busy_in_reset", 32'(busy), 32'(0));
    chk_i("t6_done_in_reset", 32'(done), 32'(0));
    chk_m("t6_o_in_reset", o, '0);
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(m19);
    kick(mk_ident(), m19);
    finish_job(1'b0, 1'b0, "t6");

    chk_i("final_queue_empty", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
